// File: rtl/fetch_pkg.sv
// Shared widths, constants and state encoding for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0;

  // Fetch FSM encoding, kept as plain constants for legacy tools.
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t BOOT = 2'd0;
  localparam fetch_state_t RUN  = 2'd1;
  localparam fetch_state_t HALT = 2'd2;

  // Word-address increment, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational priority mux for the fetch address and next PC register values.
module fetch_next_pc
  import fetch_pkg::*;
(
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  input  logic              stall,
  input  fetch_state_t      state,
  input  logic [ADDR_W-1:0] pc_reg,
  input  logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] imem_pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] if_pc_next
);

  logic replay;

  // While halted or stalled the displayed word is re-read so the memory output stays put.
  assign replay = (state == HALT) || stall;

  // Address presented to the memory this cycle.
  always_comb begin
    imem_pc = pc_reg;
    if (redirect) begin
      imem_pc = redirect_pc;
    end else if (replay) begin
      imem_pc = if_pc;
    end
  end

  // Next values of the fetch pointer and the displayed-instruction address.
  always_comb begin
    pc_next    = pc_reg;
    if_pc_next = if_pc;
    if (redirect) begin
      if_pc_next = redirect_pc;
      pc_next    = pc_inc(redirect_pc);
    end else if (halt_req) begin
      pc_next    = pc_reg;
      if_pc_next = if_pc;
    end else if (replay) begin
      pc_next    = pc_reg;
      if_pc_next = if_pc;
    end else begin
      if_pc_next = pc_reg;
      pc_next    = pc_inc(pc_reg);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, tracks the 1-cycle memory latency and
// presents {if_instr, if_pc, if_valid} to the IF/ID register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] imem_pc,
  input  logic [DATA_W-1:0] imem_instr,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus1,
  output logic              if_valid
);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] if_pc_next;
  logic              valid_next;
  logic              redirect_q;
  logic              halt_q;
  logic              stall_q;

  // Requests are masked during reset so the memory address is RESET_PC throughout.
  assign redirect_q = redirect & ~rst;
  assign halt_q     = halt_req & ~rst;
  assign stall_q    = stall & ~rst;

  fetch_next_pc u_next_pc (
    .redirect    (redirect_q),
    .redirect_pc (redirect_pc),
    .halt_req    (halt_q),
    .stall       (stall_q),
    .state       (state),
    .pc_reg      (pc_reg),
    .if_pc       (if_pc),
    .imem_pc     (imem_pc),
    .pc_next     (pc_next),
    .if_pc_next  (if_pc_next)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next state and next valid flag; redirect beats halt beats stall beats advance.
  always_comb begin
    state_next = state;
    valid_next = if_valid;
    if (redirect_q) begin
      state_next = RUN;
      valid_next = 1'b1;
    end else if (halt_q) begin
      state_next = HALT;
      valid_next = 1'b0;
    end else begin
      case (state)
        BOOT, RUN: begin
          if (!stall_q) begin
            state_next = RUN;
            valid_next = 1'b1;
          end
        end
        HALT: begin
          state_next = HALT;
          valid_next = 1'b0;
        end
        default: begin
          state_next = HALT;
          valid_next = 1'b0;
        end
      endcase
    end
  end

  // Fetch pointer and displayed-instruction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg   <= RESET_PC;
      if_pc    <= RESET_PC;
      if_valid <= 1'b0;
    end else begin
      pc_reg   <= pc_next;
      if_pc    <= if_pc_next;
      if_valid <= valid_next;
    end
  end

  // Memory data is only forwarded when it belongs to a live fetch.
  assign if_instr    = if_valid ? imem_instr : NOP_INSTR;
  assign if_pc_plus1 = pc_inc(if_pc);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a behavioural instruction-stream model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              halt_req = 1'b0;
  logic [ADDR_W-1:0] imem_pc;
  logic [DATA_W-1:0] imem_instr = '0;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic [ADDR_W-1:0] if_pc_plus1;
  logic              if_valid;

  int compared = 0;
  int mismatched = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_req    (halt_req),
    .imem_pc     (imem_pc),
    .imem_instr  (imem_instr),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus1 (if_pc_plus1),
    .if_valid    (if_valid)
  );

  always #5 clk = ~clk;

  // Memory contents: mem[i] = i + 100.
  function automatic logic [DATA_W-1:0] mem_word(input int a);
    return DATA_W'(a + 100);
  endfunction

  // Registered-read memory stub.
  always @(posedge clk) imem_instr <= mem_word(int'(imem_pc));

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: which address is on display, whether it is live, and what comes next.
  int m_pc = 0;
  int m_next = 0;
  bit m_valid = 0;
  bit m_halted = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 0; m_next = 0; m_valid = 0; m_halted = 0;
    end else if (redirect) begin
      m_pc = int'(redirect_pc);
      m_next = (int'(redirect_pc) + 1) % DEPTH;
      m_valid = 1; m_halted = 0;
    end else if (halt_req) begin
      m_valid = 0; m_halted = 1;
    end else if (!(stall || m_halted)) begin
      m_pc = m_next;
      m_next = (m_next + 1) % DEPTH;
      m_valid = 1;
    end
  end

  function automatic int exp_imem();
    if (rst) return 0;
    if (redirect) return int'(redirect_pc);
    if (m_halted || stall) return m_pc;
    return m_next;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("m_valid", int'(if_valid), int'(m_valid));
    check("m_imem_pc", int'(imem_pc), exp_imem());
    check("m_instr", int'(if_instr), m_valid ? int'(mem_word(m_pc)) : 0);
    if (m_valid) begin
      check("m_if_pc", int'(if_pc), m_pc);
      check("m_plus1", int'(if_pc_plus1), (m_pc + 1) % DEPTH);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fetch(input string name, input int pc);
    check({name, "_valid"}, int'(if_valid), 1);
    check({name, "_pc"}, int'(if_pc), pc);
    check({name, "_instr"}, int'(if_instr), pc + 100);
  endtask

  task automatic boot_seq(input string name);
    check({name, "_boot_valid"}, int'(if_valid), 0);
    check({name, "_boot_imem"}, int'(imem_pc), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_fetch(name, i);
    end
  endtask

  initial begin
    // Test 1: reset, boot, sequential fetch
    repeat (3) cyc();
    check("rst_imem", int'(imem_pc), 0);
    check("rst_instr", int'(if_instr), 0);
    rst = 1'b0;
    boot_seq("t1");
    cyc(); cyc(); cyc();
    check_fetch("t1_five", 5);

    // Test 2: stall for three cycles at if_pc=5
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_fetch("t2_stall", 5);
      check("t2_imem", int'(imem_pc), 5);
      cyc();
    end
    stall = 1'b0;
    check_fetch("t2_release", 5);
    cyc();
    check_fetch("t2_after", 6);
    cyc();
    check_fetch("t3_seven", 7);

    // Test 3: redirect, then redirect with stall
    redirect = 1'b1; redirect_pc = 13'd40;
    #1;
    check("t3_imem", int'(imem_pc), 40);
    cyc();
    redirect = 1'b0;
    check_fetch("t3_target", 40);
    cyc();
    check_fetch("t3_next", 41);
    redirect = 1'b1; stall = 1'b1; redirect_pc = 13'd40;
    cyc();
    redirect = 1'b0; stall = 1'b0;
    check_fetch("t3s_target", 40);
    cyc();
    check_fetch("t3s_next", 41);

    // Test 4: halt at if_pc=9, stalls while halted, redirect out
    redirect = 1'b1; redirect_pc = 13'd9;
    cyc();
    redirect = 1'b0;
    check_fetch("t4_nine", 9);
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      stall = (k == 3 || k == 4);
      #1;
      check("t4_valid", int'(if_valid), 0);
      check("t4_imem", int'(imem_pc), 9);
      check("t4_instr", int'(if_instr), 0);
      cyc();
    end
    stall = 1'b0;
    redirect = 1'b1; redirect_pc = 13'd0;
    cyc();
    redirect = 1'b0;
    check_fetch("t4_out", 0);

    // Test 5: wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 13'd8190;
    cyc();
    redirect = 1'b0;
    check_fetch("t5_8190", 8190);
    check("t5_p1a", int'(if_pc_plus1), 8191);
    cyc();
    check_fetch("t5_8191", 8191);
    check("t5_p1b", int'(if_pc_plus1), 0);
    cyc();
    check_fetch("t5_wrap", 0);

    // Mixed directed pattern: stall bursts and halt with simultaneous stall
    for (int k = 0; k < 12; k++) begin
      stall = (k % 3 == 1);
      halt_req = (k == 7);
      cyc();
    end
    stall = 1'b0; halt_req = 1'b0;
    cyc();
    check("mix_halted", int'(if_valid), 0);
    redirect = 1'b1; redirect_pc = 13'd100;
    cyc();
    redirect = 1'b0;
    check_fetch("mix_out", 100);
    cyc();

    // Test 6: asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    check("t6_valid", int'(if_valid), 0);
    check("t6_imem", int'(imem_pc), 0);
    check("t6_instr", int'(if_instr), 0);
    cyc(); cyc();
    rst = 1'b0;
    boot_seq("t6");

    // Halt requested in the boot cycle, then redirect out
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0;
    cyc();
    check("boot_halt_valid", int'(if_valid), 0);
    check("boot_halt_imem", int'(imem_pc), 0);
    redirect = 1'b1; redirect_pc = 13'd20;
    cyc();
    redirect = 1'b0;
    check_fetch("boot_halt_out", 20);
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
